// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a shared MUX2.
// A hold timer forces a hand-over when one side keeps the mux while the other waits.
module mux2_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic REQ_A,
  input  logic REQ_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic S,
  output logic BUSY,
  output logic PREEMPT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [CW-1:0] w_cntInc;
  logic          r_lastB;
  logic          w_lastBNext;
  logic          r_s;
  logic          w_sNext;
  logic          r_preempt;
  logic          w_preemptNext;
  logic          r_gntA;
  logic          r_gntB;
  logic          r_busy;

  assign w_cntInc = (r_cnt == HOLD_LIMIT) ? r_cnt : r_cnt + 1'b1;

  // Next-state logic; S is only rewritten on entry to an owning state so IDLE keeps it.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_lastBNext   = r_lastB;
    w_sNext       = r_s;
    w_preemptNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (REQ_A && (!REQ_B || r_lastB)) begin
          w_stateNext = OWN_A;
          w_cntNext   = '0;
          w_lastBNext = 1'b0;
          w_sNext     = 1'b0;
        end else if (REQ_B) begin
          w_stateNext = OWN_B;
          w_cntNext   = '0;
          w_lastBNext = 1'b1;
          w_sNext     = 1'b1;
        end
      end
      OWN_A: begin
        if (!REQ_A || (REQ_B && r_cnt == HOLD_LIMIT)) begin
          if (REQ_B) begin
            w_stateNext   = OWN_B;
            w_lastBNext   = 1'b1;
            w_sNext       = 1'b1;
            w_preemptNext = REQ_A;
          end else begin
            w_stateNext = IDLE;
          end
          w_cntNext = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      OWN_B: begin
        if (!REQ_B || (REQ_A && r_cnt == HOLD_LIMIT)) begin
          if (REQ_A) begin
            w_stateNext   = OWN_A;
            w_lastBNext   = 1'b0;
            w_sNext       = 1'b0;
            w_preemptNext = REQ_B;
          end else begin
            w_stateNext = IDLE;
          end
          w_cntNext = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // All outputs come straight from flops; last resets to B so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lastB   <= 1'b1;
      r_s       <= 1'b0;
      r_preempt <= 1'b0;
      r_gntA    <= 1'b0;
      r_gntB    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_lastB   <= w_lastBNext;
      r_s       <= w_sNext;
      r_preempt <= w_preemptNext;
      r_gntA    <= (w_stateNext == OWN_A);
      r_gntB    <= (w_stateNext == OWN_B);
      r_busy    <= (w_stateNext != IDLE);
    end
  end

  assign GNT_A   = r_gntA;
  assign GNT_B   = r_gntB;
  assign S       = r_s;
  assign BUSY    = r_busy;
  assign PREEMPT = r_preempt;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and randomised checks of mux2_arbiter with MAX_HOLD=8.
module tb_mux2_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic REQ_A = 1'b0;
  logic REQ_B = 1'b0;
  logic GNT_A;
  logic GNT_B;
  logic S;
  logic BUSY;
  logic PREEMPT;

  int checks = 0;
  int failures = 0;

  mux2_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
    .clk(clk),
    .reset(reset),
    .REQ_A(REQ_A),
    .REQ_B(REQ_B),
    .GNT_A(GNT_A),
    .GNT_B(GNT_B),
    .S(S),
    .BUSY(BUSY),
    .PREEMPT(PREEMPT)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    #1 reset = 1'b1;
    step();
    step();
    checks++;
    if ({GNT_A, GNT_B, S, BUSY, PREEMPT} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b want=00000", {GNT_A, GNT_B, S, BUSY, PREEMPT});
    end
    reset = 1'b0;
    step();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_no_req BUSY got=%b want=0", BUSY);
    end
  endtask

  task automatic test_single();
    int badCycles;
    REQ_A = 1'b1;
    step();
    checks++;
    if ({GNT_A, GNT_B, S, BUSY} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL single_grant {GNT_A,GNT_B,S,BUSY} got=%b want=1001", {GNT_A, GNT_B, S, BUSY});
    end
    badCycles = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (GNT_A !== 1'b1 || PREEMPT !== 1'b0) badCycles++;
    end
    checks++;
    if (badCycles != 0) begin
      failures++;
      $display("[TB] FAIL single_hold bad cycles got=%0d want=0", badCycles);
    end
    REQ_A = 1'b0;
    step();
    checks++;
    if ({BUSY, S} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_release {BUSY,S} got=%b want=00", {BUSY, S});
    end
  endtask

  task automatic test_async_reset();
    REQ_A = 1'b1;
    step();
    checks++;
    if (GNT_A !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_pre GNT_A got=%b want=1", GNT_A);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({GNT_A, GNT_B, S, BUSY} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset {GNT_A,GNT_B,S,BUSY} got=%b want=0000", {GNT_A, GNT_B, S, BUSY});
    end
    REQ_A = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_tie_and_idle();
    pulseReset();
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    step();
    checks++;
    if ({GNT_A, GNT_B, S} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL tie_first {GNT_A,GNT_B,S} got=%b want=100", {GNT_A, GNT_B, S});
    end
    REQ_A = 1'b0;
    step();
    checks++;
    if ({GNT_A, GNT_B, S, BUSY, PREEMPT} !== 5'b01110) begin
      failures++;
      $display("[TB] FAIL tie_handover {GNT_A,GNT_B,S,BUSY,PREEMPT} got=%b want=01110", {GNT_A, GNT_B, S, BUSY, PREEMPT});
    end
    REQ_B = 1'b0;
    step();
    checks++;
    if ({BUSY, S} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL idle_holds_s {BUSY,S} got=%b want=01", {BUSY, S});
    end
    REQ_A = 1'b1;
    step();
    checks++;
    if ({GNT_A, S} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL regrant_a {GNT_A,S} got=%b want=10", {GNT_A, S});
    end
    REQ_A = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int aCycles;
    int bCycles;
    int pulses;
    pulseReset();
    REQ_A = 1'b1;
    step();
    REQ_B = 1'b1;
    aCycles = 0;
    pulses = 0;
    while (GNT_A === 1'b1 && aCycles < 20) begin
      aCycles++;
      if (PREEMPT === 1'b1) pulses++;
      step();
    end
    checks++;
    if (aCycles != MAX_HOLD) begin
      failures++;
      $display("[TB] FAIL timeout_a_len got=%0d want=%0d", aCycles, MAX_HOLD);
    end
    checks++;
    if ({GNT_B, S, PREEMPT} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL timeout_handover {GNT_B,S,PREEMPT} got=%b want=111", {GNT_B, S, PREEMPT});
    end
    bCycles = 0;
    while (GNT_B === 1'b1 && bCycles < 20) begin
      bCycles++;
      if (PREEMPT === 1'b1) pulses++;
      step();
    end
    checks++;
    if (bCycles != MAX_HOLD || pulses != 1) begin
      failures++;
      $display("[TB] FAIL timeout_b_len len got=%0d want=%0d pulses got=%0d want=1", bCycles, MAX_HOLD, pulses);
    end
    checks++;
    if ({GNT_A, S, PREEMPT} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL timeout_back_to_a {GNT_A,S,PREEMPT} got=%b want=101", {GNT_A, S, PREEMPT});
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    step();
  endtask

  task automatic test_random();
    int waitA;
    int waitB;
    int badInv;
    int badWait;
    pulseReset();
    waitA = 0;
    waitB = 0;
    badInv = 0;
    badWait = 0;
    for (int i = 0; i < 1000; i++) begin
      REQ_A = ($urandom_range(0, 3) != 0);
      REQ_B = ($urandom_range(0, 3) != 0);
      step();
      if ((GNT_A & GNT_B) !== 1'b0 || BUSY !== (GNT_A | GNT_B) ||
          (GNT_A === 1'b1 && S !== 1'b0) || (GNT_B === 1'b1 && S !== 1'b1)) begin
        badInv++;
      end
      waitA = (GNT_A === 1'b1 || !REQ_A) ? 0 : waitA + 1;
      waitB = (GNT_B === 1'b1 || !REQ_B) ? 0 : waitB + 1;
      if (waitA > MAX_HOLD + 1 || waitB > MAX_HOLD + 1) badWait++;
    end
    checks++;
    if (badInv != 0) begin
      failures++;
      $display("[TB] FAIL random_invariants bad cycles got=%0d want=0", badInv);
    end
    checks++;
    if (badWait != 0) begin
      failures++;
      $display("[TB] FAIL random_wait_bound bad cycles got=%0d want=0", badWait);
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_tie_and_idle();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
